// File: rtl/fp8_mac_pkg.sv
// fp8_mac_pkg: shared state type and constants for the FP8 dot-product sequencer
package fp8_mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FP8_W = 8;
  localparam int MUL_LAT_DEF = 3;
  localparam int ADD_LAT_DEF = 3;
endpackage

// File: rtl/fp8_prod_fifo.sv
// fp8_prod_fifo: DEPTH x FP8 product buffer (push_i/din_i in, pop_i/head_o out, count_o/empty_o status)
module fp8_prod_fifo
  import fp8_mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk96,
  input  logic             rst96,
  input  logic             push_i,
  input  logic [FP8_W-1:0] din_i,
  input  logic             pop_i,
  output logic [FP8_W-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [FP8_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push_i ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop_i ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk96 or posedge rst96)
    if (rst96) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk96)
    if (push_i) mem_q[wp_q] <= din_i;
  assign head_o = mem_q[rp_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/fp8_dot_seq.sv
// fp8_dot_seq: sequences an FP8 dot product over a shared external multiplier and adder
// start/vec_len begin a job; in_* stream operand pairs; mul_*/add_* drive the external units;
// out_* present the accumulated result in DONE; busy flags any non-idle state.
module fp8_dot_seq
  import fp8_mac_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int LEN_W = 8,
  parameter int PF_DEPTH = 4
) (
  input  logic             clk96,
  input  logic             rst96,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP8_W-1:0] in_a,
  input  logic [FP8_W-1:0] in_b,
  output logic [FP8_W-1:0] mul_a,
  output logic [FP8_W-1:0] mul_b,
  input  logic [FP8_W-1:0] mul_result,
  output logic [FP8_W-1:0] add_a,
  output logic [FP8_W-1:0] add_b,
  input  logic [FP8_W-1:0] add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP8_W-1:0] out_result,
  output logic             busy
);
  localparam int CW = $clog2(PF_DEPTH + 1);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [MUL_LAT-1:0] mul_vld_q, mul_vld_d;
  logic [ADD_LAT-1:0] add_vld_q, add_vld_d;
  logic [FP8_W-1:0] acc_q, acc_d, head;
  logic acc_ld_q, acc_ld_d;
  logic [CW-1:0] count;
  logic empty, hs, push, load, issue, done_cond;
  // products still in the multiplier count against FIFO space so a push can never overflow
  assign in_ready = state_q == RUN && cnt_q < len_q && (int'(count) + $countones(mul_vld_q)) < PF_DEPTH;
  assign hs = in_valid & in_ready;
  assign push = mul_vld_q[MUL_LAT-1];
  // the first product seeds the accumulator directly, so no FP8 zero encoding is needed
  assign load = state_q == RUN && !acc_ld_q && !empty;
  assign issue = state_q == RUN && acc_ld_q && add_vld_q == '0 && !empty;
  assign done_cond = cnt_q == len_q && mul_vld_q == '0 && empty && add_vld_q == '0 && acc_ld_q;
  fp8_prod_fifo #(.DEPTH(PF_DEPTH), .CW(CW)) u_fifo (
    .clk96  (clk96),
    .rst96  (rst96),
    .push_i (push),
    .din_i  (mul_result),
    .pop_i  (load | issue),
    .head_o (head),
    .count_o(count),
    .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q + LEN_W'(hs);
    mul_vld_d = (mul_vld_q << 1) | MUL_LAT'(hs);
    add_vld_d = (add_vld_q << 1) | ADD_LAT'(issue);
    acc_ld_d = acc_ld_q | load;
    acc_d = load ? head : add_vld_q[ADD_LAT-1] ? add_result : acc_q;
    case (state_q)
      IDLE: if (start) begin
        len_d = vec_len;
        cnt_d = '0;
        acc_ld_d = 1'b0;
        acc_d = '0;
        state_d = vec_len == '0 ? DONE : RUN;
      end
      RUN: state_d = done_cond ? DONE : RUN;
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk96 or posedge rst96)
    if (rst96) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      mul_vld_q <= '0;
      add_vld_q <= '0;
      acc_q <= '0;
      acc_ld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      mul_vld_q <= mul_vld_d;
      add_vld_q <= add_vld_d;
      acc_q <= acc_d;
      acc_ld_q <= acc_ld_d;
    end
  assign mul_a = in_a;
  assign mul_b = in_b;
  assign add_a = acc_q;
  assign add_b = head;
  assign out_valid = state_q == DONE;
  assign out_result = acc_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/fp8_dot_seq.md
Name: fp8_dot_seq

Overview:
- Sequencer that computes an FP8 dot product by sharing one external pipelined FP8 multiplier and one external pipelined FP8 adder.
- Accepts a length-N stream of (a, b) operand pairs and issues each pair to the multiplier.
- Buffers the returning products in a small FIFO and serialises the accumulation through the adder. Only one add is in flight at a time, which removes the read-after-write hazard on the accumulator.
- Sits between the vector load logic and the fp8_mult_pipelined / fp8_add_pipelined instances. It contains no FP arithmetic itself.

Parameters:
- MUL_LAT, 3: edges from operand handshake to product capture (multiplier depth).
- ADD_LAT, 3: edges from add issue to sum capture (adder depth).
- LEN_W, 8: width of vector length and element counters.
- PF_DEPTH, 4: product FIFO depth; must be >= 2.

Ports:
- clk96  in  1  clock
- rst96  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a dot product; honoured only in IDLE
- vec_len  in  LEN_W  element count, sampled on accepted start; 0 is legal
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a, in_b  in  8  FP8 operands
- mul_a, mul_b  out  8  to multiplier; combinational copies of in_a/in_b
- mul_result  in  8  multiplier output
- add_a, add_b  out  8  to adder: add_a = acc, add_b = FIFO head
- add_result  in  8  adder output
- out_valid  out  1  dot-product result valid (state DONE)
- out_ready  in  1  consumer accepts result
- out_result  out  8  accumulator value
- busy  out  1  state != IDLE

Behaviour:
- Reset: already decided — reset rst96, asynchronous, active-high; clock clk96. On reset:
  - state = IDLE; all counters, valid shift registers and FIFO pointers cleared.
  - acc = 8'h00; in_ready = 0; out_valid = 0; out_result = 8'h00; busy = 0.
  - Reset mid-operation aborts the job. Products or sums still in the external pipelines are ignored, because their tracking valids are cleared.
- States: IDLE -> RUN on start (vec_len != 0); IDLE -> DONE on start with vec_len == 0 (out_result = 8'h00); RUN -> DONE when complete; DONE -> IDLE on out_ready.
- Start behaviour: start in RUN or DONE is ignored. Entering RUN clears acc_loaded, the counters and acc.
- in_ready = (state == RUN) & (accepted < len) & (fifo_count + mul_inflight < PF_DEPTH). The FIFO can therefore never overflow.
- Multiplier tracking: MUL_LAT-bit valid shift register. A handshake at edge k pushes mul_result into the FIFO at edge k+MUL_LAT. Back-to-back handshakes are allowed, one per cycle.
- First product: when acc_loaded = 0 and the FIFO is non-empty, pop the head into acc directly (no add) and set acc_loaded = 1. This avoids needing an FP8 zero encoding.
- Add issue: when acc_loaded = 1, no add is in flight and the FIFO is non-empty, pop the head and drive the add for that cycle. Set add_busy; capture add_result into acc at issue edge + ADD_LAT; clear add_busy on that same edge.
- Simultaneous FIFO push and pop in one edge is legal; the count is unchanged.
- Completion: accepted == len, mul_inflight == 0, FIFO empty, add_busy == 0 and acc_loaded == 1. RUN -> DONE is taken at the next edge.
- Output: out_result = acc, held stable in DONE while out_ready is low.
- Latency example (vec_len = 1, MUL_LAT = 3): handshake at edge k; FIFO push at k+3; acc load at k+4; DONE (out_valid = 1) after edge k+5.
- Adds per job: N-1. Steady-state input throughput is bounded by one add per ADD_LAT+1 cycles; in_ready throttles the stream accordingly.

Decomposition:
- Package fp8_mac_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - FP8_W = 8
  - default MUL_LAT and ADD_LAT constants
- Sub-module fp8_prod_fifo: synchronous PF_DEPTH x 8 FIFO with count, push, pop and head outputs, and async reset. All sequencing logic stays in fp8_dot_seq.

Test Plan:
- The bench models the multiplier as "a+b mod 256" and the adder as "a+b mod 256", both with the configured latency, so expected values are exact integers.
- vec_len = 1, pair (0x10, 0x05) -> out_valid at edge k+5 after the handshake; out_result = 0x15; held until out_ready.
- vec_len = 4, pairs (1,1), (2,2), (3,3), (4,4) with in_valid held high -> out_result = 0x14; add_busy never overlaps a second issue; FIFO count never exceeds PF_DEPTH.
- vec_len = 8 with PF_DEPTH = 2 and ADD_LAT = 6 -> in_ready throttles and no product is lost; out_result equals the model sum mod 256.
- vec_len = 0 start -> DONE on the next edge, out_result = 0x00, no mul or add activity; a start pulse while DONE is ignored.
- rst96 asserted mid-job after 3 of 6 elements, then a new job with vec_len = 2, pairs (0x20, 0x01), (0x02, 0x03) -> out_result = 0x26; stale pipeline outputs are ignored.
- out_ready held low for 10 cycles in DONE -> out_valid and out_result stable; in_ready = 0; busy = 1.
